// File: rtl/div_iter.sv
// Iterative 64/32-bit integer divider: restoring radix-2, one quotient bit per cycle.
// Zero-divisor, signed-overflow and non-divide ops bypass the loop and answer the cycle after accept.
module div_iter #(
    parameter int TAG_WIDTH = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [63:0]          src1,
    input  logic [63:0]          src2,
    input  logic [12:0]          muldiv_type,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [63:0]          result,
    output logic [TAG_WIDTH-1:0] resp_tag
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [63:0]          r_rem;
    logic [63:0]          r_quo;
    logic [63:0]          r_div;
    logic [5:0]           r_count;
    logic [5:0]           r_lastIdx;
    logic                 r_isW;
    logic                 r_isRem;
    logic                 r_negQ;
    logic                 r_negR;
    logic [63:0]          r_result;
    logic [TAG_WIDTH-1:0] r_respTag;

    logic        w_anyDiv;
    logic        w_isW;
    logic        w_isRem;
    logic        w_isSigned;
    logic        w_aNeg;
    logic        w_bNeg;
    logic [63:0] w_aExt;
    logic [63:0] w_bExt;
    logic [63:0] w_aMag;
    logic [63:0] w_bMag;
    logic [63:0] w_dividendOut;
    logic        w_bZero;
    logic        w_overflow;
    logic        w_unusedTypeBits;

    assign w_anyDiv   = |{muldiv_type[12:9], muldiv_type[7:4]};
    assign w_isW      = |muldiv_type[12:9];
    assign w_isRem    = muldiv_type[6] | muldiv_type[7] | muldiv_type[11] | muldiv_type[12];
    assign w_isSigned = muldiv_type[4] | muldiv_type[6] | muldiv_type[9] | muldiv_type[11];
    assign w_unusedTypeBits = &{1'b0, muldiv_type[3:0], muldiv_type[8]};

    // W ops see only the low word; signed ops sign-extend it so negation yields a clean magnitude.
    assign w_aExt = !w_isW     ? src1 :
                    w_isSigned ? {{32{src1[31]}}, src1[31:0]} : {32'd0, src1[31:0]};
    assign w_bExt = !w_isW     ? src2 :
                    w_isSigned ? {{32{src2[31]}}, src2[31:0]} : {32'd0, src2[31:0]};
    assign w_aNeg = w_isSigned && w_aExt[63];
    assign w_bNeg = w_isSigned && w_bExt[63];
    assign w_aMag = w_aNeg ? (64'd0 - w_aExt) : w_aExt;
    assign w_bMag = w_bNeg ? (64'd0 - w_bExt) : w_bExt;

    assign w_dividendOut = w_isW ? {{32{src1[31]}}, src1[31:0]} : src1;
    assign w_bZero       = w_isW ? (src2[31:0] == 32'd0) : (src2 == 64'd0);
    assign w_overflow    = w_isSigned &&
                           (w_isW ? (src1[31:0] == 32'h8000_0000 && src2[31:0] == 32'hFFFF_FFFF)
                                  : (src1 == 64'h8000_0000_0000_0000 && src2 == '1));

    logic [64:0] w_remShift;
    logic [64:0] w_remSub;
    logic        w_ge;
    logic [63:0] w_remNext;
    logic [63:0] w_quoNext;
    logic [63:0] w_qSigned;
    logic [63:0] w_rSigned;
    logic [63:0] w_pick;
    logic [63:0] w_final;

    assign w_remShift = {r_rem, r_quo[63]};
    assign w_ge       = w_remShift >= {1'b0, r_div};
    assign w_remSub   = w_remShift - {1'b0, r_div};
    assign w_remNext  = w_ge ? w_remSub[63:0] : w_remShift[63:0];
    assign w_quoNext  = {r_quo[62:0], w_ge};

    assign w_qSigned = r_negQ ? (64'd0 - w_quoNext) : w_quoNext;
    assign w_rSigned = r_negR ? (64'd0 - w_remNext) : w_remNext;
    assign w_pick    = r_isRem ? w_rSigned : w_qSigned;
    assign w_final   = r_isW ? {{32{w_pick[31]}}, w_pick[31:0]} : w_pick;

    // W dividends are pre-shifted into the top word so the same loop runs just 32 steps.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_count   <= '0;
            r_lastIdx <= '0;
            r_isW     <= 1'b0;
            r_isRem   <= 1'b0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_result  <= '0;
            r_respTag <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_respTag <= req_tag;
                        r_isW     <= w_isW;
                        r_isRem   <= w_isRem;
                        r_negQ    <= w_aNeg ^ w_bNeg;
                        r_negR    <= w_aNeg;
                        r_count   <= '0;
                        r_lastIdx <= w_isW ? 6'd31 : 6'd63;
                        if (!w_anyDiv) begin
                            r_result <= '0;
                            r_state  <= S_DONE;
                        end else if (w_bZero) begin
                            r_result <= w_isRem ? w_dividendOut : '1;
                            r_state  <= S_DONE;
                        end else if (w_overflow) begin
                            r_result <= w_isRem ? '0 : w_dividendOut;
                            r_state  <= S_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_isW ? {w_aMag[31:0], 32'd0} : w_aMag;
                            r_div   <= w_isW ? {32'd0, w_bMag[31:0]} : w_bMag;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem   <= w_remNext;
                    r_quo   <= w_quoNext;
                    r_count <= r_count + 6'd1;
                    if (r_count == r_lastIdx) begin
                        r_result <= w_final;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE) && !flush;
    assign resp_valid = (r_state == S_DONE);
    assign result     = r_result;
    assign resp_tag   = r_respTag;

endmodule
